// File: rtl/ex_stage_unit.sv
// Execute stage: forwarding operand muxes, single-cycle ALU, multi-cycle multiply,
// and the EX/MEM pipeline register. ex_busy stalls upstream while a multiply runs.
module ex_stage_unit #(
   parameter int MUL_LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] id_ex_rs_data,
   input  logic [31:0] id_ex_rt_data,
   input  logic [31:0] id_ex_imm,
   input  logic        id_ex_alu_src,
   input  logic [3:0]  id_ex_alu_op,
   input  logic [4:0]  id_ex_rd,
   input  logic        id_ex_reg_write,
   input  logic        id_ex_mem_read,
   input  logic        id_ex_mem_write,
   input  logic        id_ex_mem_to_reg,
   input  logic [1:0]  forward_a,
   input  logic [1:0]  forward_b,
   input  logic [31:0] mem_wb_write_data,
   input  logic        flush,
   output logic        ex_busy,
   output logic [31:0] ex_mem_alu_result,
   output logic [31:0] ex_mem_store_data,
   output logic        ex_mem_zero,
   output logic [4:0]  ex_mem_rd,
   output logic        ex_mem_reg_write,
   output logic        ex_mem_mem_read,
   output logic        ex_mem_mem_write,
   output logic        ex_mem_mem_to_reg
);

   localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
   localparam logic [3:0] OP_MUL = 4'd9;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic           busy_q, busy_d;
   logic [31:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [4:0]     mul_rd_q, mul_rd_d;
   logic [3:0]     mul_ctl_q, mul_ctl_d;
   logic [31:0]    res_q, res_d, store_q, store_d;
   logic           zero_q, zero_d;
   logic [4:0]     rd_q, rd_d;
   logic [3:0]     ctl_q, ctl_d;

   logic [31:0]    op_a, fwd_b, op_b, alu_res, product;

   always_comb begin
      case (forward_a)
         2'b10:   op_a = res_q;
         2'b01:   op_a = mem_wb_write_data;
         default: op_a = id_ex_rs_data;
      endcase
      case (forward_b)
         2'b10:   fwd_b = res_q;
         2'b01:   fwd_b = mem_wb_write_data;
         default: fwd_b = id_ex_rt_data;
      endcase
      op_b = id_ex_alu_src ? id_ex_imm : fwd_b;
   end

   always_comb begin
      case (id_ex_alu_op)
         4'd0:    alu_res = op_a & op_b;
         4'd1:    alu_res = op_a | op_b;
         4'd2:    alu_res = op_a + op_b;
         4'd3:    alu_res = op_a - op_b;
         4'd4:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
         4'd5:    alu_res = ~(op_a | op_b);
         4'd6:    alu_res = op_a ^ op_b;
         4'd7:    alu_res = op_a << op_b[4:0];
         4'd8:    alu_res = op_a >> op_b[4:0];
         default: alu_res = 32'd0;
      endcase
   end

   // Low 32 bits of a product are identical for signed and unsigned operands.
   assign product = mul_a_q * mul_b_q;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      mul_rd_d  = mul_rd_q;
      mul_ctl_d = mul_ctl_q;
      res_d     = 32'd0;
      store_d   = 32'd0;
      zero_d    = 1'b0;
      rd_d      = 5'd0;
      ctl_d     = 4'd0;
      if (flush) begin
         state_d = S_IDLE;
         count_d = '0;
      end else if (state_q == S_MUL) begin
         if (count_q == '0) begin
            res_d   = product;
            zero_d  = (product == 32'd0);
            rd_d    = mul_rd_q;
            ctl_d   = mul_ctl_q;
            state_d = S_IDLE;
         end else begin
            count_d = count_q - CW'(1);
         end
      end else if (id_ex_alu_op == OP_MUL) begin
         mul_a_d   = op_a;
         mul_b_d   = op_b;
         mul_rd_d  = id_ex_rd;
         mul_ctl_d = {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg};
         count_d   = CW'(MUL_LATENCY - 1);
         state_d   = S_MUL;
      end else begin
         res_d   = alu_res;
         store_d = fwd_b;
         zero_d  = (alu_res == 32'd0);
         rd_d    = id_ex_rd;
         ctl_d   = {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg};
      end
      busy_d = (state_d == S_MUL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         busy_q    <= 1'b0;
         mul_a_q   <= 32'd0;
         mul_b_q   <= 32'd0;
         mul_rd_q  <= 5'd0;
         mul_ctl_q <= 4'd0;
         res_q     <= 32'd0;
         store_q   <= 32'd0;
         zero_q    <= 1'b0;
         rd_q      <= 5'd0;
         ctl_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         mul_rd_q  <= mul_rd_d;
         mul_ctl_q <= mul_ctl_d;
         res_q     <= res_d;
         store_q   <= store_d;
         zero_q    <= zero_d;
         rd_q      <= rd_d;
         ctl_q     <= ctl_d;
      end
   end

   assign ex_busy           = busy_q;
   assign ex_mem_alu_result = res_q;
   assign ex_mem_store_data = store_q;
   assign ex_mem_zero       = zero_q;
   assign ex_mem_rd         = rd_q;
   assign ex_mem_reg_write  = ctl_q[3];
   assign ex_mem_mem_read   = ctl_q[2];
   assign ex_mem_mem_write  = ctl_q[1];
   assign ex_mem_mem_to_reg = ctl_q[0];

endmodule
